// File: rtl/fft_butterfly_3.sv
// Radix-2 DIT butterfly engine: X = A + W*B, Y = A - W*B.
// Three-stage pipeline with a single global stall driven by the output
// handshake. Twiddles come from an external combinational table addressed
// by the registered tw_index, so tw_index stalls together with the data.
module fft_butterfly_3 #(
  parameter int unsigned DW    = 12,
  parameter int unsigned TW    = 12,
  parameter int unsigned SHIFT = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_k,
  input  logic signed [DW-1:0] in_a_re,
  input  logic signed [DW-1:0] in_a_im,
  input  logic signed [DW-1:0] in_b_re,
  input  logic signed [DW-1:0] in_b_im,
  output logic [2:0]           tw_index,
  input  logic signed [TW-1:0] tw_rea,
  input  logic signed [TW-1:0] tw_img,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW+1:0] out_x_re,
  output logic signed [DW+1:0] out_x_im,
  output logic signed [DW+1:0] out_y_re,
  output logic signed [DW+1:0] out_y_im
);

  // Product, sum, rotated-term and output widths.
  localparam int unsigned PW  = DW + TW;
  localparam int unsigned SW  = DW + TW + 1;
  localparam int unsigned TDW = DW + 1;
  localparam int unsigned OW  = DW + 2;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  // Pipeline state.
  logic                 s1_valid;
  cplx_t                s1_a;
  cplx_t                s1_b;
  logic                 s2_valid;
  cplx_t                s2_a;
  logic signed [PW-1:0] s2_rr;
  logic signed [PW-1:0] s2_ii;
  logic signed [PW-1:0] s2_ri;
  logic signed [PW-1:0] s2_ir;

  // Combinational datapath.
  logic                  en_c;
  logic signed [DW-1:0]  b_re_c;
  logic signed [DW-1:0]  b_im_c;
  logic signed [PW-1:0]  prod_rr_c;
  logic signed [PW-1:0]  prod_ii_c;
  logic signed [PW-1:0]  prod_ri_c;
  logic signed [PW-1:0]  prod_ir_c;
  logic signed [SW-1:0]  sum_re_c;
  logic signed [SW-1:0]  sum_im_c;
  logic signed [SW-1:0]  sh_re_c;
  logic signed [SW-1:0]  sh_im_c;
  logic signed [TDW-1:0] t_re_c;
  logic signed [TDW-1:0] t_im_c;
  logic signed [DW-1:0]  a_re_c;
  logic signed [DW-1:0]  a_im_c;
  logic signed [OW-1:0]  x_re_c;
  logic signed [OW-1:0]  x_im_c;
  logic signed [OW-1:0]  y_re_c;
  logic signed [OW-1:0]  y_im_c;

  // Global stall: the whole pipe advances only when the output slot frees.
  always_comb begin
    en_c     = ~out_valid | out_ready;
    in_ready = ~rst & en_c;
  end

  // Stage 1: capture operands and address the twiddle table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      tw_index <= 3'd0;
    end else if (en_c) begin
      s1_valid <= in_valid;
      s1_a.re  <= in_a_re;
      s1_a.im  <= in_a_im;
      s1_b.re  <= in_b_re;
      s1_b.im  <= in_b_im;
      tw_index <= in_k;
    end
  end

  // Full-precision complex products of B with the table twiddle.
  always_comb begin
    b_re_c    = s1_b.re;
    b_im_c    = s1_b.im;
    prod_rr_c = PW'(b_re_c) * PW'(tw_rea);
    prod_ii_c = PW'(b_im_c) * PW'(tw_img);
    prod_ri_c = PW'(b_re_c) * PW'(tw_img);
    prod_ir_c = PW'(b_im_c) * PW'(tw_rea);
  end

  // Stage 2: register products and forward A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_a     <= '0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ri    <= '0;
      s2_ir    <= '0;
    end else if (en_c) begin
      s2_valid <= s1_valid;
      s2_a     <= s1_a;
      s2_rr    <= prod_rr_c;
      s2_ii    <= prod_ii_c;
      s2_ri    <= prod_ri_c;
      s2_ir    <= prod_ir_c;
    end
  end

  // Rotated term t = (W*B) >>> SHIFT (floor), then the butterfly sums.
  always_comb begin
    a_re_c   = s2_a.re;
    a_im_c   = s2_a.im;
    sum_re_c = SW'(s2_rr) - SW'(s2_ii);
    sum_im_c = SW'(s2_ri) + SW'(s2_ir);
    sh_re_c  = sum_re_c >>> SHIFT;
    sh_im_c  = sum_im_c >>> SHIFT;
    // |t| < 2^DW, so keeping DW+1 bits is lossless.
    t_re_c   = TDW'(sh_re_c);
    t_im_c   = TDW'(sh_im_c);
    x_re_c   = OW'(a_re_c) + OW'(t_re_c);
    x_im_c   = OW'(a_im_c) + OW'(t_im_c);
    y_re_c   = OW'(a_re_c) - OW'(t_re_c);
    y_im_c   = OW'(a_im_c) - OW'(t_im_c);
  end

  // Stage 3: registered results; held stable while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x_re  <= '0;
      out_x_im  <= '0;
      out_y_re  <= '0;
      out_y_im  <= '0;
    end else if (en_c) begin
      out_valid <= s2_valid;
      out_x_re  <= x_re_c;
      out_x_im  <= x_im_c;
      out_y_re  <= y_re_c;
      out_y_im  <= y_im_c;
    end
  end

endmodule

// File: tb/tb_fft_butterfly_3.sv
// Scoreboard bench for fft_butterfly_3 with a behavioural Q7 twiddle table.
module tb_fft_butterfly_3;

  localparam int DW = 12;
  localparam int TW = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_k;
  logic signed [DW-1:0] in_a_re, in_a_im, in_b_re, in_b_im;
  logic [2:0]           tw_index;
  logic signed [TW-1:0] tw_rea, tw_img;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW+1:0] out_x_re, out_x_im, out_y_re, out_y_im;

  fft_butterfly_3 #(.DW(DW), .TW(TW), .SHIFT(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_k(in_k),
    .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
    .tw_index(tw_index), .tw_rea(tw_rea), .tw_img(tw_img),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x_re(out_x_re), .out_x_im(out_x_im), .out_y_re(out_y_re), .out_y_im(out_y_im)
  );

  always #5 clk = ~clk;

  // W = e^(-j*2*pi*k/8) in Q7.
  function automatic int wr_of(int k);
    case (k)
      0: return 127;  1: return 90;   2: return 0;    3: return -90;
      4: return -127; 5: return -90;  6: return 0;    default: return 90;
    endcase
  endfunction

  function automatic int wi_of(int k);
    case (k)
      0: return 0;    1: return -90;  2: return -127; 3: return -90;
      4: return 0;    5: return 90;   6: return 127;  default: return 90;
    endcase
  endfunction

  always_comb begin
    tw_rea = TW'(wr_of(int'(tw_index)));
    tw_img = TW'(wi_of(int'(tw_index)));
  end

  typedef struct {
    int xr; int xi; int yr; int yi;
    int acc;
    bit lat;
  } exp_t;

  exp_t sbq[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  bit   acc_flag;
  bit   lat_mode;
  int   out_count;
  int   first_out;
  int   last_out;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic exp_t model(int k, int ar, int ai, int br, int bi);
    exp_t e;
    int tr, ti;
    tr = (br * wr_of(k) - bi * wi_of(k)) >>> 7;
    ti = (br * wi_of(k) + bi * wr_of(k)) >>> 7;
    e.xr = ar + tr; e.xi = ai + ti;
    e.yr = ar - tr; e.yi = ai - ti;
    e.acc = cyc; e.lat = lat_mode;
    return e;
  endfunction

  // Observe handshakes just after inputs settle, then advance to the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    acc_flag = in_valid && in_ready;
    if (acc_flag)
      sbq.push_back(model(int'(in_k), int'(in_a_re), int'(in_a_im), int'(in_b_re), int'(in_b_im)));
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = sbq.pop_front();
        check("x_re", int'(out_x_re), e.xr);
        check("x_im", int'(out_x_im), e.xi);
        check("y_re", int'(out_y_re), e.yr);
        check("y_im", int'(out_y_im), e.yi);
        if (e.lat) check("latency", cyc - e.acc, 3);
      end
      out_count++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int k, input int ar, input int ai, input int br, input int bi);
    int n = 0;
    in_k = 3'(k);
    in_a_re = DW'(ar); in_a_im = DW'(ai);
    in_b_re = DW'(br); in_b_im = DW'(bi);
    in_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!acc_flag && n < 20);
    if (!acc_flag) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sbq.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_empty", sbq.size(), 0);
  endtask

  function automatic int rnd();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rk [12];
    int ra [12][4];
    int idx, t;
    int snap_xr, snap_yi, snap_tw;

    rst = 1'b1; in_valid = 1'b0; in_k = '0; out_ready = 1'b1;
    in_a_re = '0; in_a_im = '0; in_b_re = '0; in_b_im = '0;
    lat_mode = 1'b1; out_count = 0; first_out = -1; last_out = -1;
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_tw_index", int'(tw_index), 0);
    check("rst_out_x_re", int'(out_x_re), 0);

    // Directed cases with latency checking.
    send(0, 100, 0, 64, 0);
    drain();
    send(2, 100, 0, 64, 0);
    drain();
    send(1, 0, 0, 128, 128);
    check("tw_index_k1", int'(tw_index), 1);
    drain();
    send(3, -2048, -2048, -2048, -2048);
    drain();

    // Back-to-back stream k=0..7.
    lat_mode = 1'b0;
    out_count = 0; first_out = -1;
    for (int i = 0; i < 8; i++) send(i, rnd(), rnd(), rnd(), rnd());
    drain();
    check("stream_count", out_count, 8);
    check("stream_run", last_out - first_out, 7);

    // Stream with 5-cycle backpressure window.
    for (int i = 0; i < 12; i++) begin
      rk[i] = int'($urandom_range(7));
      for (int j = 0; j < 4; j++) ra[i][j] = rnd();
    end
    out_count = 0; idx = 0; t = 0;
    snap_xr = 0; snap_yi = 0; snap_tw = 0;
    while ((idx < 12 || sbq.size() > 0) && t < 200) begin
      out_ready = !(t >= 6 && t < 11);
      if (idx < 12) begin
        in_valid = 1'b1; in_k = 3'(rk[idx]);
        in_a_re = DW'(ra[idx][0]); in_a_im = DW'(ra[idx][1]);
        in_b_re = DW'(ra[idx][2]); in_b_im = DW'(ra[idx][3]);
      end else in_valid = 1'b0;
      tick();
      if (acc_flag) idx++;
      if (t == 6) begin
        snap_xr = int'(out_x_re); snap_yi = int'(out_y_im); snap_tw = int'(tw_index);
      end else if (t > 6 && t < 11) begin
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_x_re_hold", int'(out_x_re), snap_xr);
        check("bp_y_im_hold", int'(out_y_im), snap_yi);
        check("bp_tw_hold", int'(tw_index), snap_tw);
      end
      t++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", out_count, 12);
    check("bp_sb_empty", sbq.size(), 0);

    // Asynchronous reset with operands in flight.
    send(5, rnd(), rnd(), rnd(), rnd());
    send(6, rnd(), rnd(), rnd(), rnd());
    send(7, rnd(), rnd(), rnd(), rnd());
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out_x_re", int'(out_x_re), 0);
    check("arst_out_y_im", int'(out_y_im), 0);
    check("arst_tw_index", int'(tw_index), 0);
    check("arst_in_ready", int'(in_ready), 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lat_mode = 1'b1;
    send(1, 0, 0, 128, 128);
    drain();
    repeat (4) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
